// File: rtl/spi_slave_pkg.sv
// Shared types and command-byte field positions for the SPI register-file responder.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int CMD_DIR_BIT  = 1;
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with registered rise/fall pulses
// aligned to the registered level output.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              q_r;
  logic              rise_r;
  logic              fall_r;

  // Synchronizer chain followed by level and edge-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      q_r    <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      q_r    <= sync_r[STAGES-1];
      rise_r <= sync_r[STAGES-1] & ~q_r;
      fall_r <= ~sync_r[STAGES-1] & q_r;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder giving an SPI master read/write access to a 32 x 8 register file,
// with a fabric side port and a strobe per committed SPI write.
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int                NUM_REGS    = 32,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 5'd25,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  input  logic              spi_SS_n,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  input  logic              fab_we,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic [DATA_W-1:0] fab_wdata,
  output logic [DATA_W-1:0] fab_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  logic sclk_rise_s, sclk_fall_s, sclk_level_unused_s;
  logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;
  logic ss_rise_s, ss_fall_s, ss_level_unused_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk_clk), .rst_n(reset_reset_n), .d(spi_SCLK),
    .q(sclk_level_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk_clk), .rst_n(reset_reset_n), .d(spi_MOSI),
    .q(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk_clk), .rst_n(reset_reset_n), .d(spi_SS_n),
    .q(ss_level_unused_s), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  state_e              state_r;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [ADDR_W-1:0]   addr_r;
  logic                dir_r;
  logic [2:0]          bit_cnt_r;
  logic [DATA_W-2:0]   rx_sr_r;
  logic [DATA_W-2:0]   tx_sr_r;
  logic                miso_r;
  logic                miso_oe_r;
  logic                busy_r;
  logic                wr_strobe_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [DATA_W-1:0]   wr_data_r;

  logic [DATA_W-1:0]   rx_byte_s;
  logic [ADDR_W-1:0]   cmd_addr_s;
  logic                spi_we_s;

  assign rx_byte_s  = {rx_sr_r, mosi_s};
  assign cmd_addr_s = rx_byte_s[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign spi_we_s   = (state_r == DATA) && dir_r && sclk_rise_s &&
                      (bit_cnt_r == 3'd7) && !ss_rise_s;

  // Transaction sequencing; miso_r always mirrors the bit about to be shifted out.
  // The fall right after a byte's 8th rise is not shifted so a freshly loaded byte keeps bit 7.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      dir_r     <= 1'b0;
      bit_cnt_r <= 3'd0;
      rx_sr_r   <= '0;
      tx_sr_r   <= '0;
      miso_r    <= 1'b0;
      miso_oe_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ss_fall_s) begin
            tx_sr_r   <= regs_r[STATUS_ADDR][DATA_W-2:0];
            miso_r    <= regs_r[STATUS_ADDR][DATA_W-1];
            miso_oe_r <= 1'b1;
            busy_r    <= 1'b1;
            bit_cnt_r <= 3'd0;
            rx_sr_r   <= '0;
            state_r   <= CMD;
          end
        end
        CMD, DATA: begin
          if (ss_rise_s) begin
            state_r   <= IDLE;
            miso_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            bit_cnt_r <= 3'd0;
          end else if (sclk_rise_s) begin
            rx_sr_r   <= rx_byte_s[DATA_W-2:0];
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              if (state_r == CMD) begin
                addr_r  <= cmd_addr_s;
                dir_r   <= rx_byte_s[CMD_DIR_BIT];
                state_r <= DATA;
                if (!rx_byte_s[CMD_DIR_BIT]) begin
                  tx_sr_r <= regs_r[cmd_addr_s][DATA_W-2:0];
                  miso_r  <= regs_r[cmd_addr_s][DATA_W-1];
                end
              end else if (!dir_r) begin
                tx_sr_r <= regs_r[addr_r][DATA_W-2:0];
                miso_r  <= regs_r[addr_r][DATA_W-1];
              end
            end
          end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
            miso_r  <= tx_sr_r[DATA_W-2];
            tx_sr_r <= {tx_sr_r[DATA_W-3:0], 1'b0};
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Register file: the SPI commit is applied after the fabric write so it wins a same-address clash
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
    end else begin
      if (fab_we) regs_r[fab_addr] <= fab_wdata;
      if (spi_we_s) regs_r[addr_r] <= rx_byte_s;
    end
  end

  // Write-notification strobe and last-write capture
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
    end else begin
      wr_strobe_r <= spi_we_s;
      if (spi_we_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= rx_byte_s;
      end
    end
  end

  assign spi_MISO    = miso_r;
  assign spi_MISO_oe = miso_oe_r;
  assign busy        = busy_r;
  assign wr_strobe   = wr_strobe_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign fab_rdata   = regs_r[fab_addr];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: transaction-level register model, strobe scoreboard
// and idle-state checks every cycle, plus literal expectations for each scenario.
module tb_spi_slave_regfile;

  localparam int HALF = 8;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic       spi_SCLK = 1'b0;
  logic       spi_MOSI = 1'b0;
  logic       spi_SS_n = 1'b1;
  logic       spi_MISO, spi_MISO_oe;
  logic       fab_we = 1'b0;
  logic [4:0] fab_addr = 5'd0;
  logic [7:0] fab_wdata = 8'd0;
  logic [7:0] fab_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  spi_slave_regfile dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .spi_SCLK(spi_SCLK), .spi_MOSI(spi_MOSI), .spi_SS_n(spi_SS_n),
    .spi_MISO(spi_MISO), .spi_MISO_oe(spi_MISO_oe),
    .fab_we(fab_we), .fab_addr(fab_addr), .fab_wdata(fab_wdata), .fab_rdata(fab_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  model_regs [32];
  logic [12:0] exp_wr_q [$];
  logic [4:0]  last_a = 5'd0;
  logic [7:0]  last_d = 8'd0;
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_log [$];
  logic [12:0] strobe_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Compare process: strobe scoreboard always, idle-state outputs when settled
  always @(negedge clk_clk) begin
    if (wr_strobe) begin
      n_strobe++;
      chk("wr_strobe_pending", exp_wr_q.size() != 0, 1'b1);
      if (exp_wr_q.size() != 0) begin
        strobe_e = exp_wr_q.pop_front();
        chk("wr_addr_strobe", wr_addr, strobe_e[12:8]);
        chk("wr_data_strobe", wr_data, strobe_e[7:0]);
      end
    end
    if (chk_en) begin
      chk("miso_oe_idle", spi_MISO_oe, 1'b0);
      chk("miso_idle", spi_MISO, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("fab_rdata", fab_rdata, model_regs[fab_addr]);
      chk("wr_addr_hold", wr_addr, last_a);
      chk("wr_data_hold", wr_data, last_d);
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < n; i++) begin
      spi_MOSI = b[7-i];
      wait_clk(HALF);
      spi_SCLK = 1'b1;
      rx[7-i] = spi_MISO;
      wait_clk(HALF);
      spi_SCLK = 1'b0;
    end
  endtask

  // Last data byte with a fabric write to addr 7 held until the SPI commit cycle
  task automatic spi_collide_byte(input logic [7:0] b);
    logic [7:0] rx;
    bit seen;
    spi_bits(b, 7, rx);
    spi_MOSI = b[0];
    wait_clk(HALF);
    fab_addr = 5'd7; fab_wdata = 8'h44; fab_we = 1'b1;
    spi_SCLK = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      wait_clk(1);
      seen = wr_strobe;
    end
    fab_we = 1'b0;
    chk("collide_strobe_seen", seen, 1'b1);
    wait_clk(HALF);
    spi_SCLK = 1'b0;
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input int nfull, input int part_bits,
                         input bit collide);
    logic [7:0] rx, d;
    logic [4:0] a;
    bit wr;
    a = cmd[7:3];
    wr = cmd[1];
    chk_en = 1'b0;
    spi_SS_n = 1'b0;
    wait_clk(HALF);
    chk("busy_selected", busy, 1'b1);
    chk("miso_oe_selected", spi_MISO_oe, 1'b1);
    spi_bits(cmd, 8, rx);
    rx_log.push_back(rx);
    chk("miso_status", rx, model_regs[25]);
    for (int k = 0; k < nfull; k++) begin
      d = tx_q.pop_front();
      if (wr) begin
        model_regs[a] = d;
        last_a = a;
        last_d = d;
        exp_wr_q.push_back({a, d});
      end
      if (collide && k == nfull - 1) spi_collide_byte(d);
      else begin
        spi_bits(d, 8, rx);
        if (!wr) begin
          rx_log.push_back(rx);
          chk("miso_read", rx, model_regs[a]);
        end
      end
    end
    if (part_bits > 0) begin
      d = tx_q.pop_front();
      spi_bits(d, part_bits, rx);
    end
    wait_clk(HALF);
    spi_SS_n = 1'b1;
    wait_clk(HALF);
    chk_en = 1'b1;
  endtask

  task automatic fab_write(input logic [4:0] a, input logic [7:0] d);
    fab_addr = a; fab_wdata = d; fab_we = 1'b1;
    wait_clk(1);
    fab_we = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [7:0] exp);
    fab_addr = a;
    wait_clk(1);
    chk(name, fab_rdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    for (int i = 0; i < 32; i++) model_regs[i] = 8'd0;

    // Reset state
    wait_clk(3);
    chk("rst_miso", spi_MISO, 1'b0);
    chk("rst_miso_oe", spi_MISO_oe, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 8'd0);
    chk("rst_busy", busy, 1'b0);
    reset_reset_n = 1'b1;
    wait_clk(5);
    chk_en = 1'b1;

    // Single write: 0x52 (addr 10, write) + 0xA5
    tx_q = '{8'hA5};
    spi_txn(8'h52, 1, 0, 1'b0);
    peek("lit_reg10_a5", 5'd10, 8'hA5);
    chk("lit_strobes_1", n_strobe, 1);
    chk("lit_wr_addr_10", wr_addr, 5'd10);
    chk("lit_wr_data_a5", wr_data, 8'hA5);

    // Read: status 0x3C during command, reg[4]=0x81 during the data byte
    fab_write(5'd25, 8'h3C);
    fab_write(5'd4, 8'h81);
    rx_log.delete();
    tx_q = '{8'h00};
    spi_txn(8'h20, 1, 0, 1'b0);
    chk("lit_status_3c", rx_log[0], 8'h3C);
    chk("lit_read_81", rx_log[1], 8'h81);
    chk("lit_strobes_read", n_strobe, 1);

    // Multi-byte write to addr 1, no auto-increment
    tx_q = '{8'h11, 8'h22, 8'h33};
    spi_txn(8'h0A, 3, 0, 1'b0);
    chk("lit_strobes_4", n_strobe, 4);
    peek("lit_reg1_33", 5'd1, 8'h33);
    peek("lit_reg2_untouched", 5'd2, 8'h00);
    chk("lit_wr_addr_1", wr_addr, 5'd1);

    // Abort after 5 data bits
    tx_q = '{8'hFF};
    spi_txn(8'h52, 0, 5, 1'b0);
    chk("lit_abort_strobes", n_strobe, 4);
    peek("lit_abort_reg10", 5'd10, 8'hA5);
    chk("lit_abort_oe", spi_MISO_oe, 1'b0);

    // Zero-data transaction
    spi_txn(8'h0A, 0, 0, 1'b0);
    chk("lit_zero_strobes", n_strobe, 4);
    peek("lit_zero_reg1", 5'd1, 8'h33);

    // Collision at addr 7: SPI 0x99 vs fabric 0x44
    tx_q = '{8'h99};
    spi_txn(8'h3A, 1, 0, 1'b1);
    peek("lit_collide_reg7", 5'd7, 8'h99);
    chk("lit_collide_strobes", n_strobe, 5);

    // Reset in the middle of a write data byte
    chk_en = 1'b0;
    fab_addr = 5'd10;
    spi_SS_n = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h77, 4, rx);
    reset_reset_n = 1'b0;
    #1;
    chk("midrst_miso", spi_MISO, 1'b0);
    chk("midrst_miso_oe", spi_MISO_oe, 1'b0);
    chk("midrst_wr_strobe", wr_strobe, 1'b0);
    chk("midrst_wr_addr", wr_addr, 5'd0);
    chk("midrst_wr_data", wr_data, 8'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_fab_rdata", fab_rdata, 8'd0);
    for (int i = 0; i < 32; i++) model_regs[i] = 8'd0;
    last_a = 5'd0;
    last_d = 8'd0;
    exp_wr_q.delete();
    wait_clk(3);
    reset_reset_n = 1'b1;
    wait_clk(10);
    chk("postrst_no_restart_busy", busy, 1'b0);
    chk("postrst_no_restart_oe", spi_MISO_oe, 1'b0);
    spi_SS_n = 1'b1;
    wait_clk(HALF);
    chk_en = 1'b1;

    // Next full transaction works normally
    tx_q = '{8'hA5};
    spi_txn(8'h52, 1, 0, 1'b0);
    peek("lit_post_reg10", 5'd10, 8'hA5);
    chk("lit_post_strobes", n_strobe, 6);
    rx_log.delete();
    tx_q = '{8'h00};
    spi_txn(8'h50, 1, 0, 1'b0);
    chk("lit_post_status_0", rx_log[0], 8'h00);
    chk("lit_post_read_a5", rx_log[1], 8'hA5);

    // Sweep the whole register file through the fabric port
    for (int a = 0; a < 32; a++) begin
      fab_addr = a[4:0];
      wait_clk(1);
    end
    chk("exp_strobes_drained", exp_wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI responder (mode 0, MSB first) that lets the SoC's SPI master read and write a 32 x 8 register file in FPGA fabric.
- Uses the same command-byte framing as the USB host controller on the SPI bus:
  - command byte = {addr[4:0], 1'b0, dir, 1'b0}; dir=1 is write, dir=0 is read.
  - zero or more data bytes follow, all to the same address.
- Fabric logic gets a side port for register access and a strobe for every SPI write.

Parameters:
- NUM_REGS, 32, number of 8-bit registers; address width is fixed at 5.
- STATUS_ADDR, 5'd25, register whose value is shifted out on MISO during the command byte.
- SYNC_STAGES, 2, synchronizer depth on SCLK/MOSI/SS_n.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- spi_SCLK  in  1  SPI clock from master, asynchronous to clk_clk.
- spi_MOSI  in  1  master-out data.
- spi_SS_n  in  1  active-low select.
- spi_MISO  out  1  slave-out data.
- spi_MISO_oe  out  1  high while selected.
- fab_we  in  1  fabric write enable.
- fab_addr  in  5  fabric read/write address.
- fab_wdata  in  8  fabric write data.
- fab_rdata  out  8  reg[fab_addr], combinational read.
- wr_strobe  out  1  one-cycle pulse per committed SPI write.
- wr_addr  out  5  address of last SPI write.
- wr_data  out  8  data of last SPI write.
- busy  out  1  high while SS_n is low (synchronized).

Behaviour:
- Reset:
  - all registers, shift registers and counters go to 0; state IDLE.
  - spi_MISO=0, spi_MISO_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
- Input synchronization: SCLK, MOSI and SS_n each pass through SYNC_STAGES flops. Edges are detected on the synced SCLK (rise = sample, fall = shift).
- Timing requirements on the master: SCLK period ≥ 8 clk_clk; SS_n-low to first SCLK rise ≥ 4 clk_clk.
- State machine IDLE -> CMD -> DATA:
  - IDLE:
    - on synced SS_n falling edge, load tx_sr <= reg[STATUS_ADDR], bit_cnt <= 0, go to CMD.
    - spi_MISO=tx_sr[7] and spi_MISO_oe=1 from the next cycle.
  - CMD:
    - each SCLK rise: rx_sr <= {rx_sr[6:0], MOSI}, bit_cnt++.
    - each SCLK fall: tx_sr <= tx_sr<<1.
    - on the 8th rise: latch addr=rx[7:3] and dir=rx[1]; bit_cnt <= 0; go to DATA.
    - if dir=0, tx_sr <= reg[addr] on that cycle, so data bit 7 is valid before the next rise.
  - DATA, per byte:
    - write, on 8th rise: reg[addr] <= byte; wr_strobe pulses on the next cycle with wr_addr/wr_data.
    - read, on 8th rise: tx_sr <= reg[addr] is reloaded for the next byte; fabric updates are visible per byte.
  - Any state, on SS_n rise: go to IDLE, discard a partial byte (no write, no strobe), spi_MISO_oe=0, spi_MISO=0.
- Bits 2 and 0 of the command byte are ignored.
- Address is fixed for the whole transaction; no auto-increment.
- Collision: SPI commit and fab_we in the same cycle to the same address -> SPI data wins. Different addresses -> both take effect.
- fab_rdata reflects a write on the cycle after the write.
- Zero-data-byte transaction (SS_n rises right after the command byte) -> no effect besides the status read.
- Asynchronous reset mid-transaction: immediate return to reset values. The next transaction requires a fresh SS_n falling edge.
- SCLK edges while SS_n is high are ignored.

Decomposition:
- Package spi_slave_pkg:
  - state enum {IDLE, CMD, DATA}.
  - constants CMD_DIR_BIT=1, CMD_ADDR_MSB=7, CMD_ADDR_LSB=3, ADDR_W=5, DATA_W=8.
- Sub-module spi_sync_edge: N-stage synchronizer plus rise/fall pulse outputs. Instantiate it once each for SCLK, MOSI and SS_n.

Test Plan:
- Write: reset, SS_n low, send 0x52 (addr 10, write) then 0xA5, SS_n high -> reg[10]=0xA5, one wr_strobe with wr_addr=10, wr_data=0xA5, fab_rdata(10)=0xA5.
- Read: fab writes reg[25]=0x3C and reg[4]=0x81; SPI read 0x20 + one dummy byte -> MISO returns 0x3C during the command byte and 0x81 during the data byte.
- Multi-byte write: send 0x0A then 0x11, 0x22, 0x33 -> three wr_strobes, all addr 1; reg[1]=0x33.
- Abort: send 0x52 then only 5 data bits, SS_n high -> reg[10] unchanged, no wr_strobe, MISO_oe=0.
- Collision: SPI commit to addr 7 with 0x99 in the same cycle as fab_we addr 7 data 0x44 -> reg[7]=0x99.
- Reset mid-transfer: assert reset_reset_n low during DATA -> all outputs 0 immediately. The next full transaction works normally.
